// File: rtl/neuron_accum_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : neuron_accum_if                                              |
// | Description : Stream bundle for neuron_accum. It carries the incoming     |
// |               Q1.6 term stream (in_*) and the outgoing saturated result    |
// |               stream (out_*).                                              |
// |               slave  : the accumulator side. It consumes in_* and          |
// |                        produces out_*.                                     |
// |               master : the surrounding logic. It drives in_* and out_ready.|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface neuron_accum_if;
   logic       in_valid;   // in_data carries a term
   logic       in_ready;   // accumulator accepts a term this cycle
   logic [7:0] in_data;    // signed Q1.6 term
   logic       out_valid;  // out_data/out_ovr hold a result
   logic       out_ready;  // downstream accepts the result
   logic [7:0] out_data;   // signed Q1.6 saturated sum
   logic       out_ovr;    // saturation occurred for this result

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ovr
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ovr
   );
endinterface
`default_nettype wire

// File: rtl/neuron_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : neuron_accum                                                 |
// | Description : Sums N_IN consecutive signed Q1.6 terms at full ACC_W        |
// |               precision. It saturates the final sum to 8-bit Q1.6, flags   |
// |               overflow, and holds one registered result on a valid/ready   |
// |               output.                                                      |
// | Ports       : clk    - rising-edge clock                                   |
// |               rst    - asynchronous active-low reset                       |
// |               enable - freezes all state when low                          |
// |               bus    - neuron_accum_if.slave. Provides the in_valid/       |
// |                        in_ready/in_data term stream and the out_valid/     |
// |                        out_ready/out_data/out_ovr result stream.           |
// |               busy   - a group is in progress or a result is held          |
// | Options     : NEURON_ACCUM_RELU_EN - applies ReLU after saturation. A      |
// |               negative result becomes 0x00, and out_ovr keeps the          |
// |               saturation flag.                                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module neuron_accum #(
   parameter int N_IN  = 4,   // terms per output, >= 1
   parameter int ACC_W = 12   // >= 8 + ceil(log2(N_IN))
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       enable,
   neuron_accum_if.slave   bus,
   output      logic       busy
);

   localparam int                    c_cnt_w   = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [c_cnt_w-1:0]    c_last    = c_cnt_w'(N_IN - 1);
   localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'(127);
   localparam logic signed [ACC_W-1:0] c_sat_min = ACC_W'(-128);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t                    r_state,     w_state_nxt;
   logic signed [ACC_W-1:0]   r_acc,       w_acc_nxt;
   logic [c_cnt_w-1:0]        r_cnt,       w_cnt_nxt;
   logic                      r_out_valid, w_out_valid_nxt;
   logic [7:0]                r_out_data,  w_out_data_nxt;
   logic                      r_out_ovr,   w_out_ovr_nxt;

   logic                      w_in_ready;
   logic                      w_accept;
   logic signed [ACC_W-1:0]   w_term;
   logic signed [ACC_W-1:0]   w_sum;
   logic [7:0]                w_sat_data;
   logic                      w_sat_ovr;
   logic [7:0]                w_res_data;

   // in_ready comes only from registered state and enable. It has no
   // combinational path from in_valid.
   assign w_in_ready = enable & (r_state != S_HOLD);
   assign w_accept   = bus.in_valid & w_in_ready;

   // acc is zero whenever the FSM is in IDLE. The same adder therefore
   // serves the first term and later terms. in_data reaches state only
   // through w_accept, so X on in_data while in_valid is low never
   // propagates.
   assign w_term = ACC_W'($signed(bus.in_data));
   assign w_sum  = r_acc + w_term;

   always_comb begin
      w_sat_data = w_sum[7:0];
      w_sat_ovr  = 1'b0;
      if (w_sum > c_sat_max) begin
         w_sat_data = 8'h7F;
         w_sat_ovr  = 1'b1;
      end else if (w_sum < c_sat_min) begin
         w_sat_data = 8'h80;
         w_sat_ovr  = 1'b1;
      end
   end

`ifdef NEURON_ACCUM_RELU_EN
   assign w_res_data = w_sat_data[7] ? 8'h00 : w_sat_data;
`else
   assign w_res_data = w_sat_data;
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_cnt_nxt       = r_cnt;
      w_out_valid_nxt = r_out_valid;
      w_out_data_nxt  = r_out_data;
      w_out_ovr_nxt   = r_out_ovr;
      case (r_state)
         S_IDLE, S_ACCUM: begin
            if (w_accept) begin
               // cnt counts the terms already summed. When N_IN is 1,
               // the first term is also the final term.
               if (r_cnt == c_last) begin
                  w_out_data_nxt  = w_res_data;
                  w_out_ovr_nxt   = w_sat_ovr;
                  w_out_valid_nxt = 1'b1;
                  w_acc_nxt       = '0;
                  w_cnt_nxt       = '0;
                  w_state_nxt     = S_HOLD;
               end else begin
                  w_acc_nxt   = w_sum;
                  w_cnt_nxt   = r_cnt + c_cnt_w'(1);
                  w_state_nxt = S_ACCUM;
               end
            end
         end
         S_HOLD: begin
            if (enable && bus.out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_state_nxt     = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= 8'h00;
         r_out_ovr   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_cnt       <= w_cnt_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_ovr   <= w_out_ovr_nxt;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_ovr   = r_out_ovr;
   assign busy          = (r_state == S_ACCUM) | (r_state == S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_neuron_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_neuron_accum                                              |
// | Description : Directed self-checking bench for neuron_accum with N_IN=4    |
// |               and ACC_W=12. The vectors cover back-to-back groups,         |
// |               saturation, backpressure, stalls, gaps and asynchronous      |
// |               reset.                                                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_neuron_accum;

   logic clk = 1'b0;
   logic rst;
   logic enable;
   logic busy;
   int   n_checks = 0;
   int   n_fail   = 0;

`ifdef NEURON_ACCUM_RELU_EN
   localparam logic [7:0] c_exp_neg_sat = 8'h00;
   localparam logic [7:0] c_exp_fe      = 8'h00;
`else
   localparam logic [7:0] c_exp_neg_sat = 8'h80;
   localparam logic [7:0] c_exp_fe      = 8'hFE;
`endif

   neuron_accum_if u_if ();

   neuron_accum #(
      .N_IN  (4),
      .ACC_W (12)
   ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .bus    (u_if),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one term for one cycle. Consecutive calls are back-to-back.
   task automatic feed(input logic [7:0] t);
      u_if.in_valid = 1'b1;
      u_if.in_data  = t;
      check("in_ready_on_feed", {31'd0, u_if.in_ready}, 32'd1);
      @(posedge clk); #1;
      u_if.in_valid = 1'b0;
      u_if.in_data  = 'x;
   endtask

   task automatic check_result(input logic [7:0] d, input logic o);
      check("out_valid_result", {31'd0, u_if.out_valid}, 32'd1);
      check("out_data_result",  {24'd0, u_if.out_data},  {24'd0, d});
      check("out_ovr_result",   {31'd0, u_if.out_ovr},   {31'd0, o});
      check("in_ready_in_hold", {31'd0, u_if.in_ready},  32'd0);
      check("busy_in_hold",     {31'd0, busy},           32'd1);
   endtask

   task automatic drain(input logic [7:0] d);
      u_if.out_ready = 1'b1;
      @(posedge clk); #1;
      u_if.out_ready = 1'b0;
      check("out_valid_drop",    {31'd0, u_if.out_valid}, 32'd0);
      check("in_ready_restored", {31'd0, u_if.in_ready},  32'd1);
      check("busy_idle",         {31'd0, busy},           32'd0);
      check("out_data_retained", {24'd0, u_if.out_data},  {24'd0, d});
   endtask

   task automatic group4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input logic [7:0] ed, input logic eo);
      feed(a);
      feed(b);
      feed(c);
      check("out_valid_early", {31'd0, u_if.out_valid}, 32'd0);
      feed(d);
      check_result(ed, eo);
      drain(ed);
   endtask

   task automatic check_reset_outputs();
      check("rst_out_valid", {31'd0, u_if.out_valid}, 32'd0);
      check("rst_out_data",  {24'd0, u_if.out_data},  32'd0);
      check("rst_out_ovr",   {31'd0, u_if.out_ovr},   32'd0);
      check("rst_busy",      {31'd0, busy},           32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b0;
      enable         = 1'b1;
      u_if.in_valid  = 1'b0;
      u_if.in_data   = 'x;
      u_if.out_ready = 1'b0;
      #2;
      check_reset_outputs();
      @(posedge clk); #1;
      check_reset_outputs();
      rst = 1'b1;
      @(posedge clk); #1;

      // Main function and saturation boundaries
      group4(8'h10, 8'h10, 8'h10, 8'h10, 8'h40, 1'b0);
      group4(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1);
      group4(8'h80, 8'h80, 8'h80, 8'h80, c_exp_neg_sat, 1'b1);
      group4(8'h7F, 8'h7F, 8'h80, 8'h80, c_exp_fe, 1'b0);
      group4(8'h40, 8'hC0, 8'h20, 8'hF0, 8'h10, 1'b0);

      // Backpressure: the held result must stay put and offered terms must be refused
      feed(8'h05); feed(8'h05); feed(8'h05); feed(8'h05);
      u_if.in_valid = 1'b1;
      u_if.in_data  = 8'h7F;
      for (int i = 0; i < 5; i++) begin
         check_result(8'h14, 1'b0);
         @(posedge clk); #1;
      end
      u_if.in_valid = 1'b0;
      u_if.in_data  = 'x;
      // A handshake while enable is low must be ignored
      enable         = 1'b0;
      u_if.out_ready = 1'b1;
      @(posedge clk); #1;
      check("hold_stalled_valid", {31'd0, u_if.out_valid}, 32'd1);
      u_if.out_ready = 1'b0;
      enable         = 1'b1;
      drain(8'h14);

      // Stall and gaps inside a group
      feed(8'h08);
      feed(8'h08);
      enable        = 1'b0;
      u_if.in_valid = 1'b1;
      u_if.in_data  = 8'h7F;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("stall_in_ready", {31'd0, u_if.in_ready}, 32'd0);
         check("stall_busy",     {31'd0, busy},          32'd1);
         @(posedge clk); #1;
      end
      enable        = 1'b1;
      u_if.in_valid = 1'b0;
      u_if.in_data  = 'x;
      repeat (2) @(posedge clk);
      #1;
      check("gap_out_valid", {31'd0, u_if.out_valid}, 32'd0);
      check("gap_busy",      {31'd0, busy},           32'd1);
      feed(8'h08);
      feed(8'h08);
      check_result(8'h20, 1'b0);
      drain(8'h20);

      // Asynchronous reset mid-group drops the partial sum
      feed(8'h20);
      feed(8'h20);
      #3;
      rst = 1'b0;
      #1;
      check_reset_outputs();
      @(posedge clk); #1;
      check_reset_outputs();
      rst = 1'b1;
      @(posedge clk); #1;
      group4(8'h01, 8'h01, 8'h01, 8'h01, 8'h04, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
